// File: rtl/mem_addr_seq_pkg.sv
// Shared types and helpers for the memory address sequencer.
// Optional feature macro: MEM_ADDR_SEQ_ERR_EN (adds the err output; see mem_addr_seq).
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned ADDR_WIDTH_DEF   = 8;
  localparam int unsigned WIDTH_HEIGHT_DEF = 16;

  // Width of num_row/num_col: must hold 0..W inclusive.
  function automatic int unsigned lane_cnt_w(input int unsigned w);
    return unsigned'($clog2(w)) + 1;
  endfunction

  // Width of the step counter: must hold the longest skewed job, 2W-1.
  function automatic int unsigned step_cnt_w(input int unsigned w);
    return unsigned'($clog2(2 * w));
  endfunction

  function automatic int unsigned clamp_cnt(input int unsigned n, input int unsigned w);
    return (n > w) ? w : n;
  endfunction

  // True when lane idx issues a row at this step of a job with the given shape.
  function automatic logic lane_hit(input int unsigned step, input int unsigned idx,
                                    input int unsigned rows, input int unsigned cols,
                                    input logic skew);
    if (idx >= cols) return 1'b0;
    if (!skew) return step < rows;
    return (step >= idx) && ((step - idx) < rows);
  endfunction

endpackage

// File: rtl/mem_addr_seq_lane_gen.sv
// One lane of the address sequencer: keeps the lane's running row address and
// registers its address/valid for the step the controller presents.
module mem_lane_gen
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width = ADDR_WIDTH_DEF,
  parameter int unsigned cnt_w      = 3,
  parameter int unsigned step_w     = 3,
  parameter int unsigned lane_idx   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  en,
  input  logic [step_w-1:0]     step,
  input  logic [cnt_w-1:0]      num_row,
  input  logic [cnt_w-1:0]      num_col,
  input  logic                  skew,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width-1:0] stride,
  output logic [addr_width-1:0] addr,
  output logic                  valid
);

  logic [addr_width-1:0] run_q, run_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [addr_width-1:0] cur;

  // Emit the running address when this lane is active, then advance it by stride.
  always_comb begin
    cur     = load ? base_addr : run_q;
    run_d   = cur;
    addr_d  = '0;
    valid_d = 1'b0;
    if ((load || en) &&
        lane_hit(32'(step), lane_idx, 32'(num_row), 32'(num_col), skew)) begin
      valid_d = 1'b1;
      addr_d  = cur;
      run_d   = cur + stride;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr  = addr_q;
  assign valid = valid_q;

endmodule

// File: rtl/mem_addr_seq.sv
// Per-lane SRAM read address sequencer with broadcast / diagonal-skew modes.
// Optional feature macro: MEM_ADDR_SEQ_ERR_EN -- adds err output and rejects
// out-of-range or zero num_row/num_col instead of clamping.
module mem_addr_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width   = ADDR_WIDTH_DEF,
  parameter int unsigned width_height = WIDTH_HEIGHT_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               skew,
  input  logic [addr_width-1:0]              base_addr,
  input  logic [addr_width-1:0]              stride,
  input  logic [$clog2(width_height):0]      num_row,
  input  logic [$clog2(width_height):0]      num_col,
  output logic [addr_width*width_height-1:0] out_addr,
  output logic [width_height-1:0]            lane_valid,
  output logic                               busy,
  output logic                               done
`ifdef MEM_ADDR_SEQ_ERR_EN
  ,
  output logic                               err
`endif
);

  localparam int unsigned CNT_W  = lane_cnt_w(width_height);
  localparam int unsigned STEP_W = step_cnt_w(width_height);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   t_q, t_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic                skew_q, skew_d;
  logic [addr_width-1:0] stride_q, stride_d;

  logic [CNT_W-1:0]    row_in, col_in;
  logic [STEP_W-1:0]   t_in;
  logic                load, en;
  logic [STEP_W-1:0]   step_lane;
`ifdef MEM_ADDR_SEQ_ERR_EN
  logic                err_q, err_d;
  logic                bad_in;
`endif

  // Clamp the requested job shape and derive its length in steps.
  always_comb begin
    row_in = CNT_W'(clamp_cnt(32'(num_row), width_height));
    col_in = CNT_W'(clamp_cnt(32'(num_col), width_height));
    if (row_in == '0 || col_in == '0) t_in = '0;
    else if (skew) t_in = STEP_W'(32'(row_in) + 32'(col_in) - 32'd1);
    else t_in = STEP_W'(row_in);
`ifdef MEM_ADDR_SEQ_ERR_EN
    bad_in = (32'(num_row) > width_height) || (32'(num_col) > width_height) ||
             (num_row == '0) || (num_col == '0);
`endif
  end

  // Control FSM: step 0 is issued on the accepting edge, so RUN only advances
  // steps 1..T-1 and the final RUN edge clears the lanes while entering DONE.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    t_d       = t_q;
    row_d     = row_q;
    col_d     = col_q;
    skew_d    = skew_q;
    stride_d  = stride_q;
    load      = 1'b0;
    en        = 1'b0;
    step_lane = '0;
`ifdef MEM_ADDR_SEQ_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (step_q == t_q - STEP_W'(1)) begin
          state_d = DONE;
        end else begin
          en        = 1'b1;
          step_d    = step_q + STEP_W'(1);
          step_lane = step_q + STEP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          row_d    = row_in;
          col_d    = col_in;
          skew_d   = skew;
          stride_d = stride;
          t_d      = t_in;
          step_d   = '0;
`ifdef MEM_ADDR_SEQ_ERR_EN
          if (bad_in) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else
`endif
          if (t_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            load    = 1'b1;
          end
        end
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      t_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      skew_q   <= 1'b0;
      stride_q <= '0;
`ifdef MEM_ADDR_SEQ_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      t_q      <= t_d;
      row_q    <= row_d;
      col_q    <= col_d;
      skew_q   <= skew_d;
      stride_q <= stride_d;
`ifdef MEM_ADDR_SEQ_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
`ifdef MEM_ADDR_SEQ_ERR_EN
  assign err  = err_q;
`endif

  for (genvar gi = 0; gi < width_height; gi++) begin : g_lane
    mem_lane_gen #(
      .addr_width(addr_width),
      .cnt_w     (CNT_W),
      .step_w    (STEP_W),
      .lane_idx  (gi)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .en       (en),
      .step     (step_lane),
      .num_row  (row_d),
      .num_col  (col_d),
      .skew     (skew_d),
      .base_addr(base_addr),
      .stride   (stride_d),
      .addr     (out_addr[gi*addr_width +: addr_width]),
      .valid    (lane_valid[gi])
    );
  end

endmodule

// File: tb/tb_mem_addr_seq.sv
// Testbench for mem_addr_seq (W=4, addr_width=8); honours MEM_ADDR_SEQ_ERR_EN.
module tb_mem_addr_seq;

  localparam int unsigned AW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned NW = $clog2(W) + 1;

  logic              clk = 1'b0;
  logic              reset, start, skew;
  logic [AW-1:0]     base_addr, stride;
  logic [NW-1:0]     num_row, num_col;
  logic [AW*W-1:0]   out_addr;
  logic [W-1:0]      lane_valid;
  logic              busy, done;
`ifdef MEM_ADDR_SEQ_ERR_EN
  logic              err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  // Reference model: job parameters and cycles elapsed since acceptance.
  bit m_active = 1'b0;
  bit m_skew, m_err;
  int m_k, m_T, m_R, m_C, m_base, m_stride;
  logic [AW*W-1:0] e_addr;
  logic [W-1:0]    e_valid;
  logic            e_busy, e_done, e_err;

  always #5 clk = ~clk;

  mem_addr_seq #(
    .addr_width  (AW),
    .width_height(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .skew      (skew),
    .base_addr (base_addr),
    .stride    (stride),
    .num_row   (num_row),
    .num_col   (num_col),
    .out_addr  (out_addr),
    .lane_valid(lane_valid),
    .busy      (busy),
    .done      (done)
`ifdef MEM_ADDR_SEQ_ERR_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit busy_now;
    int nr, nc, s, r;
    if (reset) begin
      m_active = 1'b0;
      m_k      = 0;
    end else begin
      busy_now = m_active && (m_k >= 1) && (m_k <= m_T);
      if (start && !busy_now) begin
        nr       = int'(num_row);
        nc       = int'(num_col);
        m_skew   = skew;
        m_base   = int'(base_addr);
        m_stride = int'(stride);
        m_err    = 1'b0;
        m_R      = (nr > W) ? W : nr;
        m_C      = (nc > W) ? W : nc;
`ifdef MEM_ADDR_SEQ_ERR_EN
        if (nr > W || nc > W || nr == 0 || nc == 0) begin
          m_err = 1'b1;
          m_R   = 0;
        end
`endif
        if (m_R == 0 || m_C == 0) m_T = 0;
        else m_T = m_skew ? (m_R + m_C - 1) : m_R;
        m_active = 1'b1;
        m_k      = 1;
      end else if (m_active) begin
        m_k++;
        if (m_k > m_T + 1) m_active = 1'b0;
      end
    end
    e_addr  = '0;
    e_valid = '0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (m_active) begin
      if (m_k <= m_T) begin
        e_busy = 1'b1;
        s = m_k - 1;
        for (int i = 0; i < int'(W); i++) begin
          r = m_skew ? (s - i) : s;
          if (i < m_C && r >= 0 && r < m_R) begin
            e_valid[i]            = 1'b1;
            e_addr[i*AW +: AW]    = AW'(m_base + r * m_stride);
          end
        end
      end else begin
        e_done = 1'b1;
        e_err  = m_err;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("out_addr", 64'(out_addr), 64'(e_addr));
    chk("lane_valid", 64'(lane_valid), 64'(e_valid));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
`ifdef MEM_ADDR_SEQ_ERR_EN
    chk("err", 64'(err), 64'(e_err));
`endif
  endtask

  task automatic drive(input logic sk, input int b, input int st, input int nr, input int nc);
    skew      = sk;
    base_addr = AW'(b);
    stride    = AW'(st);
    num_row   = NW'(nr);
    num_col   = NW'(nc);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Broadcast job
    drive(1'b0, 'h10, 1, 3, 4);
    start = 1'b1; tick(); start = 1'b0;
    chk("tp_bcast_c1_addr", 64'(out_addr), 64'h10101010);
    chk("tp_bcast_c1_valid", 64'(lane_valid), 64'hF);
    tick(); tick();
    chk("tp_bcast_c3_addr", 64'(out_addr), 64'h12121212);
    tick();
    chk("tp_bcast_c4_done", 64'(done), 64'h1);
    tick();

    // Skewed job
    drive(1'b1, 'h20, 2, 2, 3);
    start = 1'b1; tick(); start = 1'b0;
    chk("tp_skew_c1_valid", 64'(lane_valid), 64'h1);
    tick();
    chk("tp_skew_c2_valid", 64'(lane_valid), 64'h3);
    tick();
    chk("tp_skew_c3_valid", 64'(lane_valid), 64'h6);
    chk("tp_skew_c3_addr", 64'(out_addr), 64'h00202200);
    tick();
    chk("tp_skew_c4_valid", 64'(lane_valid), 64'h4);
    tick();
    chk("tp_skew_c5_done", 64'(done), 64'h1);
    tick();

    // Address wrap
    drive(1'b0, 'hFE, 1, 3, 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("tp_wrap_c3_addr", 64'(out_addr), 64'h0);
    chk("tp_wrap_c3_valid", 64'(lane_valid), 64'h1);
    tick(); tick();

    // Reset mid-operation, then a fresh job
    drive(1'b0, 'h30, 4, 4, 4);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("tp_rst_c3_busy", 64'(busy), 64'h0);
    tick();
    drive(1'b1, 'h50, 1, 2, 2);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Zero-length job
    drive(1'b0, 'h11, 1, 0, 4);
    start = 1'b1; tick(); start = 1'b0;
    chk("tp_zero_c1_done", 64'(done), 64'h1);
    tick();

    // Start while busy is ignored
    drive(1'b0, 'h60, 1, 4, 4);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    drive(1'b1, 'hAA, 7, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Start in the DONE cycle
    drive(1'b0, 'h70, 2, 2, 2);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10 && !e_done; i++) tick();
    drive(1'b1, 'h80, 3, 3, 4);
    start = 1'b1; tick(); start = 1'b0;
    chk("tp_b2b_c1_valid", 64'(lane_valid), 64'h1);
    for (int i = 0; i < 8; i++) tick();

    // Oversized num_row
    drive(1'b0, 'h40, 3, 7, 2);
    start = 1'b1; tick(); start = 1'b0;
`ifdef MEM_ADDR_SEQ_ERR_EN
    chk("tp_clamp_err", 64'(err), 64'h1);
    chk("tp_clamp_done", 64'(done), 64'h1);
    tick();
`else
    tick(); tick(); tick();
    chk("tp_clamp_c4_valid", 64'(lane_valid), 64'h3);
    chk("tp_clamp_c4_addr", 64'(out_addr), 64'h00004949);
    tick();
    chk("tp_clamp_c5_done", 64'(done), 64'h1);
    tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)));
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
